// File: rtl/spi_burst_ctrl_if.sv
// Byte-engine link between spi_burst_ctrl (master modport) and the spi_m
// SPI master byte engine (slave modport).
`timescale 1ns/1ps
interface spi_burst_ctrl_if;
   logic        spi_start;
   logic [7:0]  spi_din;
   logic [15:0] spi_dvsr;
   logic        spi_cpol;
   logic        spi_cpha;
   logic        spi_ready;
   logic        spi_done;
   logic [7:0]  spi_dout;

   modport master (
      output spi_start, spi_din, spi_dvsr, spi_cpol, spi_cpha,
      input  spi_ready, spi_done, spi_dout
   );

   modport slave (
      input  spi_start, spi_din, spi_dvsr, spi_cpol, spi_cpha,
      output spi_ready, spi_done, spi_dout
   );
endinterface

// File: rtl/spi_burst_ctrl.sv
// Burst controller in front of spi_m: TX/RX FIFOs, byte sequencing, framed cs_n.
// Optional SPI_BURST_IRQ_EN adds a sticky irq output with an irq_clr input.
`timescale 1ns/1ps
module spi_burst_ctrl #(
   parameter int FIFO_DEPTH = 16,
   parameter int CS_SETUP   = 2,
   parameter int CS_HOLD    = 2,
   parameter int BYTE_GAP   = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [7:0]  wr_data,
   input  logic        rd_en,
   output logic [7:0]  rd_data,
   input  logic        go,
   input  logic [7:0]  len,
   input  logic        cfg_cpol,
   input  logic        cfg_cpha,
   input  logic [15:0] cfg_dvsr,
   output logic        busy,
   output logic        burst_done,
   output logic        tx_full,
   output logic        tx_empty,
   output logic        rx_full,
   output logic        rx_empty,
   output logic        rx_ovf,
   output logic        cs_n,
`ifdef SPI_BURST_IRQ_EN
   output logic        irq,
   input  logic        irq_clr,
`endif
   spi_burst_ctrl_if.master spi
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);
   // The last SETUP/HOLD/GAP cycle is the one that acts, so loads are one short.
   localparam logic [15:0] SETUP_LOAD = 16'(CS_SETUP - 1);
   localparam logic [15:0] HOLD_LOAD  = 16'(CS_HOLD - 1);
   localparam logic [15:0] GAP_LOAD   = (BYTE_GAP == 0) ? 16'd0 : 16'(BYTE_GAP - 1);

   typedef enum logic [2:0] {IDLE, SETUP, LAUNCH, WAIT, GAP, HOLD} state_t;

   state_t      state_reg, state_next;
   logic [15:0] dly_reg, dly_next;
   logic [8:0]  cnt_reg, cnt_next;
   logic        cs_n_reg, cs_n_next;
   logic        busy_reg, busy_next;
   logic        burst_done_reg, burst_done_next;
   logic        start_reg, start_next;
   logic [7:0]  din_reg, din_next;
   logic [15:0] dvsr_reg, dvsr_next;
   logic        cpol_reg, cpol_next;
   logic        cpha_reg, cpha_next;
   logic        rx_ovf_reg;

   logic [7:0]  tx_mem [FIFO_DEPTH];
   logic [7:0]  rx_mem [FIFO_DEPTH];
   logic [AW:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
   logic [AW:0] rx_wr_ptr_reg, rx_rd_ptr_reg;

   logic fire, launch_ok, tx_pop, tx_push;
   logic rx_push_req, rx_push, rx_pop, rx_drop;

   assign tx_empty = (tx_wr_ptr_reg == tx_rd_ptr_reg);
   assign tx_full  = (tx_wr_ptr_reg[AW] != tx_rd_ptr_reg[AW]) &&
                     (tx_wr_ptr_reg[AW-1:0] == tx_rd_ptr_reg[AW-1:0]);
   assign rx_empty = (rx_wr_ptr_reg == rx_rd_ptr_reg);
   assign rx_full  = (rx_wr_ptr_reg[AW] != rx_rd_ptr_reg[AW]) &&
                     (rx_wr_ptr_reg[AW-1:0] == rx_rd_ptr_reg[AW-1:0]);
   assign rd_data  = rx_mem[rx_rd_ptr_reg[AW-1:0]];

   assign tx_push  = wr_en && !tx_full;
   assign rx_pop   = rd_en && !rx_empty;
   // A full RX still accepts a byte when the host pops in the same cycle.
   assign rx_push  = rx_push_req && (!rx_full || rd_en);
   assign rx_drop  = rx_push_req && rx_full && !rd_en;
   assign launch_ok = spi.spi_ready && !tx_empty;

   always_comb begin
      state_next      = state_reg;
      dly_next        = dly_reg;
      cnt_next        = cnt_reg;
      cs_n_next       = cs_n_reg;
      busy_next       = busy_reg;
      burst_done_next = 1'b0;
      start_next      = 1'b0;
      din_next        = din_reg;
      dvsr_next       = dvsr_reg;
      cpol_next       = cpol_reg;
      cpha_next       = cpha_reg;
      fire            = 1'b0;
      tx_pop          = 1'b0;
      rx_push_req     = 1'b0;

      case (state_reg)
         IDLE: begin
            if (go) begin
               state_next = SETUP;
               cs_n_next  = 1'b0;
               busy_next  = 1'b1;
               cnt_next   = (len == 8'd0) ? 9'd256 : {1'b0, len};
               dly_next   = SETUP_LOAD;
               dvsr_next  = cfg_dvsr;
               cpol_next  = cfg_cpol;
               cpha_next  = cfg_cpha;
            end
         end
         SETUP: begin
            if (dly_reg != 16'd0) begin
               dly_next = dly_reg - 16'd1;
            end else if (launch_ok) begin
               fire = 1'b1;
            end else begin
               state_next = LAUNCH;
            end
         end
         LAUNCH: begin
            if (launch_ok) begin
               fire = 1'b1;
            end
         end
         WAIT: begin
            if (spi.spi_done) begin
               rx_push_req = 1'b1;
               cnt_next    = cnt_reg - 9'd1;
               if (cnt_reg == 9'd1) begin
                  state_next = HOLD;
                  dly_next   = HOLD_LOAD;
               end else begin
                  state_next = GAP;
                  dly_next   = GAP_LOAD;
               end
            end
         end
         GAP: begin
            if (dly_reg != 16'd0) begin
               dly_next = dly_reg - 16'd1;
            end else begin
               state_next = LAUNCH;
            end
         end
         HOLD: begin
            if (dly_reg != 16'd0) begin
               dly_next = dly_reg - 16'd1;
            end else begin
               state_next      = IDLE;
               cs_n_next       = 1'b1;
               busy_next       = 1'b0;
               burst_done_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      if (fire) begin
         state_next = WAIT;
         start_next = 1'b1;
         din_next   = tx_mem[tx_rd_ptr_reg[AW-1:0]];
         tx_pop     = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         dly_reg        <= '0;
         cnt_reg        <= '0;
         cs_n_reg       <= 1'b1;
         busy_reg       <= 1'b0;
         burst_done_reg <= 1'b0;
         start_reg      <= 1'b0;
         din_reg        <= '0;
         dvsr_reg       <= '0;
         cpol_reg       <= 1'b0;
         cpha_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         dly_reg        <= dly_next;
         cnt_reg        <= cnt_next;
         cs_n_reg       <= cs_n_next;
         busy_reg       <= busy_next;
         burst_done_reg <= burst_done_next;
         start_reg      <= start_next;
         din_reg        <= din_next;
         dvsr_reg       <= dvsr_next;
         cpol_reg       <= cpol_next;
         cpha_reg       <= cpha_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wr_ptr_reg <= '0;
         tx_rd_ptr_reg <= '0;
         rx_wr_ptr_reg <= '0;
         rx_rd_ptr_reg <= '0;
         rx_ovf_reg    <= 1'b0;
      end else begin
         if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + PTR_ONE;
         if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + PTR_ONE;
         if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + PTR_ONE;
         if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + PTR_ONE;
         if (rx_drop) rx_ovf_reg    <= 1'b1;
      end
   end

   // Storage is not reset; emptiness comes from the pointers alone.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr_reg[AW-1:0]] <= wr_data;
      if (rx_push) rx_mem[rx_wr_ptr_reg[AW-1:0]] <= spi.spi_dout;
   end

`ifdef SPI_BURST_IRQ_EN
   logic irq_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_reg <= 1'b0;
      end else if (burst_done_next || rx_drop) begin
         irq_reg <= 1'b1;
      end else if (irq_clr) begin
         irq_reg <= 1'b0;
      end
   end

   assign irq = irq_reg;
`endif

   assign cs_n          = cs_n_reg;
   assign busy          = busy_reg;
   assign burst_done    = burst_done_reg;
   assign rx_ovf        = rx_ovf_reg;
   assign spi.spi_start = start_reg;
   assign spi.spi_din   = din_reg;
   assign spi.spi_dvsr  = dvsr_reg;
   assign spi.spi_cpol  = cpol_reg;
   assign spi.spi_cpha  = cpha_reg;

endmodule
